// File: rtl/sfx_pkg.sv
// Shared constants, state type and helpers for the sound-effect scheduler.
package sfx_pkg;

    localparam int unsigned CNT_W  = 24;
    localparam int unsigned SRC_W  = 3;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned PEND_W = 3;
    localparam int unsigned DIR_W  = 4;

    localparam logic [SRC_W-1:0] SRC_NONE  = 3'd0;
    localparam logic [SRC_W-1:0] SRC_MOVE  = 3'd1;
    localparam logic [SRC_W-1:0] SRC_LEVEL = 3'd2;
    localparam logic [SRC_W-1:0] SRC_WIN   = 3'd3;
    localparam logic [SRC_W-1:0] SRC_DEATH = 3'd4;

    localparam int unsigned LEN_DEATH = 3;
    localparam int unsigned LEN_WIN   = 4;
    localparam int unsigned LEN_LEVEL = 2;

    localparam logic [SEL_W-1:0] DEATH_SEL0 = 3'd6;
    localparam logic [SEL_W-1:0] DEATH_SEL1 = 3'd4;
    localparam logic [SEL_W-1:0] DEATH_SEL2 = 3'd2;
    localparam logic [SEL_W-1:0] WIN_SEL0   = 3'd1;
    localparam logic [SEL_W-1:0] WIN_SEL1   = 3'd3;
    localparam logic [SEL_W-1:0] WIN_SEL2   = 3'd5;
    localparam logic [SEL_W-1:0] WIN_SEL3   = 3'd7;
    localparam logic [SEL_W-1:0] LEVEL_SEL0 = 3'd3;
    localparam logic [SEL_W-1:0] LEVEL_SEL1 = 3'd5;
    localparam logic [SEL_W-1:0] MOVE_SEL_UP    = 3'd4;
    localparam logic [SEL_W-1:0] MOVE_SEL_DOWN  = 3'd3;
    localparam logic [SEL_W-1:0] MOVE_SEL_LEFT  = 3'd2;
    localparam logic [SEL_W-1:0] MOVE_SEL_RIGHT = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } sfxStateT;

    // Movement tone follows the highest held direction bit.
    function automatic logic [SEL_W-1:0] moveSel(input logic [DIR_W-1:0] dir);
        logic [SEL_W-1:0] s;
        s = '0;
        if (dir[3])      s = MOVE_SEL_UP;
        else if (dir[2]) s = MOVE_SEL_DOWN;
        else if (dir[1]) s = MOVE_SEL_LEFT;
        else if (dir[0]) s = MOVE_SEL_RIGHT;
        return s;
    endfunction

    // Request bits are {DEATH, WIN, LEVEL}; returns the winning source code.
    function automatic logic [SRC_W-1:0] topSrc(input logic [PEND_W-1:0] req);
        logic [SRC_W-1:0] s;
        s = SRC_NONE;
        if (req[2])      s = SRC_DEATH;
        else if (req[1]) s = SRC_WIN;
        else if (req[0]) s = SRC_LEVEL;
        return s;
    endfunction

    function automatic logic [PEND_W-1:0] srcMask(input logic [SRC_W-1:0] src);
        logic [PEND_W-1:0] m;
        m = '0;
        case (src)
            SRC_LEVEL: m = 3'b001;
            SRC_WIN:   m = 3'b010;
            SRC_DEATH: m = 3'b100;
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sfx_jingle_rom.sv
// Jingle note table: (source, note index) -> tone select and last-note flag.
module sfx_jingle_rom
    import sfx_pkg::*;
(
    input  logic [SRC_W-1:0] src,
    input  logic [IDX_W-1:0] idx,
    output logic [SEL_W-1:0] sel,
    output logic             last
);

    always_comb begin
        sel  = '0;
        last = 1'b1;
        case (src)
            SRC_DEATH: begin
                last = (idx == IDX_W'(LEN_DEATH - 1));
                case (idx)
                    2'd0:    sel = DEATH_SEL0;
                    2'd1:    sel = DEATH_SEL1;
                    default: sel = DEATH_SEL2;
                endcase
            end
            SRC_WIN: begin
                last = (idx == IDX_W'(LEN_WIN - 1));
                case (idx)
                    2'd0:    sel = WIN_SEL0;
                    2'd1:    sel = WIN_SEL1;
                    2'd2:    sel = WIN_SEL2;
                    default: sel = WIN_SEL3;
                endcase
            end
            SRC_LEVEL: begin
                last = (idx == IDX_W'(LEN_LEVEL - 1));
                sel  = (idx == 2'd0) ? LEVEL_SEL0 : LEVEL_SEL1;
            end
            default: begin
                sel  = '0;
                last = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Fixed-priority sound scheduler time-sharing one tone generator.
// Define SFX_PENDING_EN to latch lower-priority events and play them afterwards.
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int unsigned NOTE_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 1_250_000,
    parameter int unsigned MOVE_TICKS = 5_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIR_W-1:0] move_dir,
    input  logic             player_dead,
    input  logic             level_complete,
    input  logic             game_win,
    input  logic             mute,
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic             busy,
    output logic [SRC_W-1:0] cur_src
);

    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TICKS - 1);

    sfxStateT          state, nextState;
    logic [SRC_W-1:0]  srcD, startSrc, candTop, arriveTop;
    logic [IDX_W-1:0]  idxQ, idxD;
    logic [CNT_W-1:0]  cntQ, cntD, noteLast;
    logic [PEND_W-1:0] arrive, cand, pendQ;
    logic [SEL_W-1:0]  selD, romSel;
    logic              lastQ, lastD, romLast, enD, busyD, enter, preempt;

    assign arrive    = {player_dead, game_win, level_complete};
    assign cand      = pendQ | arrive;
    assign candTop   = topSrc(cand);
    assign arriveTop = topSrc(arrive);
    assign preempt   = (arriveTop != SRC_NONE) && (arriveTop >= cur_src);
    assign noteLast  = (cur_src == SRC_MOVE) ? MOVE_LAST : NOTE_LAST;

`ifdef SFX_PENDING_EN
    logic [PEND_W-1:0] pendD;

    // Anything that arrives and is not started now waits; started source clears.
    assign pendD = cand & ~srcMask(startSrc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pendQ <= '0;
        else      pendQ <= pendD;
    end
`else
    assign pendQ = '0;
`endif

    sfx_jingle_rom uRom (
        .src  (srcD),
        .idx  (idxD),
        .sel  (romSel),
        .last (romLast)
    );

    // Next-state, counter and note-index decisions.
    always_comb begin
        nextState = state;
        srcD      = cur_src;
        idxD      = idxQ;
        cntD      = '0;
        enter     = 1'b0;
        startSrc  = SRC_NONE;
        case (state)
            IDLE: begin
                if (candTop != SRC_NONE)  startSrc = candTop;
                else if (move_dir != '0)  startSrc = SRC_MOVE;
            end
            NOTE: begin
                cntD = cntQ + CNT_W'(1);
                if (preempt) begin
                    startSrc = arriveTop;
                end else if (cntQ == noteLast) begin
                    nextState = GAP;
                    cntD      = '0;
                end
            end
            GAP: begin
                cntD = cntQ + CNT_W'(1);
                if (preempt) begin
                    startSrc = arriveTop;
                end else if (cntQ == GAP_LAST) begin
                    cntD = '0;
                    if (lastQ) begin
                        nextState = IDLE;
                        srcD      = SRC_NONE;
                        idxD      = '0;
                    end else begin
                        nextState = NOTE;
                        idxD      = idxQ + IDX_W'(1);
                        enter     = 1'b1;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
        if (startSrc != SRC_NONE) begin
            nextState = NOTE;
            srcD      = startSrc;
            idxD      = '0;
            cntD      = '0;
            enter     = 1'b1;
        end
    end

    // Output values for the next cycle; sel is only reloaded on note entry.
    always_comb begin
        selD  = sel;
        lastD = lastQ;
        if (enter) begin
            selD  = (srcD == SRC_MOVE) ? moveSel(move_dir) : romSel;
            lastD = romLast;
        end
        enD   = (nextState == NOTE) && !mute;
        busyD = (nextState != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cur_src <= SRC_NONE;
            idxQ    <= '0;
            cntQ    <= '0;
            lastQ   <= 1'b0;
            sel     <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= nextState;
            cur_src <= srcD;
            idxQ    <= idxD;
            cntQ    <= cntD;
            lastQ   <= lastD;
            sel     <= selD;
            en      <= enD;
            busy    <= busyD;
        end
    end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: vector table, directed corner sequences and random
// traffic, all checked against a per-cycle output timeline model.
`timescale 1ns/1ps
module tb_sfx_scheduler;

    localparam int unsigned NT = 4;
    localparam int unsigned GT = 2;
    localparam int unsigned MT = 3;
`ifdef SFX_PENDING_EN
    localparam bit PEND_ON = 1'b1;
`else
    localparam bit PEND_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] move_dir;
    logic       player_dead, level_complete, game_win, mute;
    logic [2:0] sel;
    logic       en, busy;
    logic [2:0] cur_src;

    sfx_scheduler #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .MOVE_TICKS(MT)) dut (
        .clk            (clk),
        .rst            (rst),
        .move_dir       (move_dir),
        .player_dead    (player_dead),
        .level_complete (level_complete),
        .game_win       (game_win),
        .mute           (mute),
        .sel            (sel),
        .en             (en),
        .busy           (busy),
        .cur_src        (cur_src)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic [2:0] src;
    } outT;

    typedef struct packed {
        logic       lc;
        logic       gw;
        logic       pd;
        logic [3:0] md;
        logic       mu;
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic [2:0] src;
    } vecT;

    // Model: the remaining output timeline of the sound being played.
    outT        tl[$];
    outT        cur;
    logic       expEn;
    logic [4:0] pend;
    int         jLen[5];
    int         jSel[5][4];
    vecT        vt[$];
    int         nCmp = 0;
    int         nBad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int hiOf(input logic [4:0] v);
        for (int k = 4; k >= 2; k--) if (v[k]) return k;
        return 0;
    endfunction

    function automatic int moveTone(input logic [3:0] d);
        for (int b = 3; b >= 0; b--) if (d[b]) return b + 1;
        return 0;
    endfunction

    task automatic modelReset();
        tl.delete();
        cur   = '0;
        expEn = 1'b0;
        pend  = '0;
    endtask

    task automatic build(input int src);
        outT e;
        int  n, s, dur;
        tl.delete();
        n = (src == 1) ? 1 : jLen[src];
        for (int i = 0; i < n; i++) begin
            s   = (src == 1) ? moveTone(move_dir) : jSel[src][i];
            dur = (src == 1) ? int'(MT) : int'(NT);
            e.sel  = 3'(s);
            e.busy = 1'b1;
            e.src  = 3'(src);
            e.en   = 1'b1;
            for (int c = 0; c < dur; c++) tl.push_back(e);
            e.en   = 1'b0;
            for (int c = 0; c < int'(GT); c++) tl.push_back(e);
        end
    endtask

    task automatic modelStep();
        logic [4:0] arr, all;
        int         top, best;
        arr    = '0;
        arr[2] = level_complete;
        arr[3] = game_win;
        arr[4] = player_dead;
        top    = hiOf(arr);
        if (!cur.busy) begin
            all  = arr | pend;
            best = hiOf(all);
            if (best != 0) begin
                build(best);
                all[best] = 1'b0;
                if (PEND_ON) pend = all;
            end else if (move_dir != 4'b0) begin
                build(1);
            end
        end else begin
            if (top != 0 && top >= int'(cur.src)) begin
                build(top);
                arr[top] = 1'b0;
            end
            if (PEND_ON) pend = pend | arr;
        end
        if (tl.size() > 0) begin
            cur = tl.pop_front();
        end else begin
            cur.en   = 1'b0;
            cur.busy = 1'b0;
            cur.src  = 3'd0;
        end
        expEn = cur.en & ~mute;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) modelReset();
        else      modelStep();
        #1;
        check("model", {sel, en, busy, cur_src}, {cur.sel, expEn, cur.busy, cur.src});
    endtask

    task automatic addVec(input logic lc, gw, pd, input logic [3:0] md, input logic mu,
                          input logic [2:0] s, input logic e, b, input logic [2:0] src);
        vecT v;
        v.lc = lc; v.gw = gw; v.pd = pd; v.md = md; v.mu = mu;
        v.sel = s; v.en = e; v.busy = b; v.src = src;
        vt.push_back(v);
    endtask

    initial begin
        rst = 1'b1; move_dir = '0; mute = 1'b0;
        player_dead = 1'b0; level_complete = 1'b0; game_win = 1'b0;
        modelReset();
        jLen = '{0, 1, 2, 4, 3};
        jSel[0] = '{0, 0, 0, 0};
        jSel[1] = '{0, 0, 0, 0};
        jSel[2] = '{3, 5, 0, 0};
        jSel[3] = '{1, 3, 5, 7};
        jSel[4] = '{6, 4, 2, 0};

        // LEVEL jingle from idle, then movement blips (plain and muted).
        addVec(1, 0, 0, 4'b0000, 0, 3'd3, 1, 1, 3'd2);
        repeat (3) addVec(0, 0, 0, 4'b0000, 0, 3'd3, 1, 1, 3'd2);
        repeat (2) addVec(0, 0, 0, 4'b0000, 0, 3'd3, 0, 1, 3'd2);
        repeat (4) addVec(0, 0, 0, 4'b0000, 0, 3'd5, 1, 1, 3'd2);
        repeat (2) addVec(0, 0, 0, 4'b0000, 0, 3'd5, 0, 1, 3'd2);
        addVec(0, 0, 0, 4'b0000, 0, 3'd5, 0, 0, 3'd0);
        addVec(0, 0, 0, 4'b0100, 0, 3'd3, 1, 1, 3'd1);
        repeat (2) addVec(0, 0, 0, 4'b0000, 0, 3'd3, 1, 1, 3'd1);
        repeat (2) addVec(0, 0, 0, 4'b0000, 0, 3'd3, 0, 1, 3'd1);
        addVec(0, 0, 0, 4'b0000, 0, 3'd3, 0, 0, 3'd0);
        addVec(0, 0, 0, 4'b1001, 0, 3'd4, 1, 1, 3'd1);
        repeat (2) addVec(0, 0, 0, 4'b0000, 0, 3'd4, 1, 1, 3'd1);
        repeat (2) addVec(0, 0, 0, 4'b0000, 0, 3'd4, 0, 1, 3'd1);
        addVec(0, 0, 0, 4'b0000, 0, 3'd4, 0, 0, 3'd0);
        addVec(0, 0, 0, 4'b0001, 1, 3'd1, 0, 1, 3'd1);
        repeat (4) addVec(0, 0, 0, 4'b0000, 1, 3'd1, 0, 1, 3'd1);
        addVec(0, 0, 0, 4'b0000, 0, 3'd1, 0, 0, 3'd0);

        // Asynchronous reset takes effect before any clock edge.
        #2 rst = 1'b0;
        #1 check("reset_async", {sel, en, busy, cur_src}, 8'h00);
        tick(); tick();
        rst = 1'b1;
        tick(); tick();

        foreach (vt[i]) begin
            level_complete = vt[i].lc;
            game_win       = vt[i].gw;
            player_dead    = vt[i].pd;
            move_dir       = vt[i].md;
            mute           = vt[i].mu;
            tick();
            check($sformatf("vec%0d", i), {sel, en, busy, cur_src},
                  {vt[i].sel, vt[i].en, vt[i].busy, vt[i].src});
        end
        level_complete = 1'b0; game_win = 1'b0; player_dead = 1'b0;
        move_dir = '0; mute = 1'b0;
        tick();

        // DEATH preempts WIN during its second note; WIN is never resumed.
        game_win = 1'b1; tick(); game_win = 1'b0;
        repeat (6) tick();
        check("win_idx1", 8'({sel, en, cur_src}), 8'({3'd3, 1'b1, 3'd3}));
        player_dead = 1'b1; tick(); player_dead = 1'b0;
        check("death_preempt", 8'({sel, en, cur_src}), 8'({3'd6, 1'b1, 3'd4}));
        repeat (17) tick();
        check("death_last_gap", 8'({sel, en, busy, cur_src}), 8'({3'd2, 1'b0, 1'b1, 3'd4}));
        tick();
        check("death_done", 8'({busy, cur_src}), 8'h00);
        repeat (5) tick();
        check("no_win_resume", 8'({busy, cur_src}), 8'h00);

        // LEVEL and WIN together: WIN first, one idle cycle, then LEVEL if latched.
        level_complete = 1'b1; game_win = 1'b1; tick();
        level_complete = 1'b0; game_win = 1'b0;
        check("simul_win", 8'({sel, cur_src}), 8'({3'd1, 3'd3}));
        repeat (23) tick();
        tick();
        check("simul_idle", 8'({busy, cur_src}), 8'h00);
        tick();
        check("simul_after", 8'({sel, busy, cur_src}),
              PEND_ON ? 8'({3'd3, 1'b1, 3'd2}) : 8'({3'd7, 1'b0, 3'd0}));
        repeat (14) tick();

        // Held movement repeats blip + gap + idle; release finishes current blip.
        move_dir = 4'b0100; tick();
        check("move_start", 8'({sel, en, busy, cur_src}), 8'({3'd3, 1'b1, 1'b1, 3'd1}));
        repeat (5) tick();
        check("move_idle", 8'({en, busy, cur_src}), 8'h00);
        tick();
        check("move_repeat", 8'({sel, en, busy, cur_src}), 8'({3'd3, 1'b1, 1'b1, 3'd1}));
        repeat (8) tick();
        move_dir = 4'b0000;
        repeat (6) tick();
        check("move_release", 8'({busy, cur_src}), 8'h00);

        // Muted DEATH: same sequencing, en never rises.
        mute = 1'b1; player_dead = 1'b1; tick(); player_dead = 1'b0;
        check("mute_start", 8'({sel, en, busy, cur_src}), 8'({3'd6, 1'b0, 1'b1, 3'd4}));
        for (int c = 0; c < 17; c++) begin
            tick();
            check("mute_en", 8'({en, busy}), 8'({1'b0, 1'b1}));
        end
        tick();
        check("mute_done", 8'({en, busy, cur_src}), 8'h00);
        mute = 1'b0;

        // Reset in the middle of a jingle.
        game_win = 1'b1; tick(); game_win = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1 check("reset_mid", {sel, en, busy, cur_src}, 8'h00);
        modelReset();
        tick();
        rst = 1'b1;
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            level_complete = ($urandom_range(0, 29) == 0);
            game_win       = ($urandom_range(0, 39) == 0);
            player_dead    = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 39) == 0)
                move_dir = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            if ($urandom_range(0, 59) == 0) mute = ~mute;
            rst = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
